// File: rtl/stream_mux_rr.sv
// N-input round-robin stream merger with packet lock and a registered, source-tagged output.
//
// state  | meaning
// IDLE   | no packet open; the round-robin candidate may start one
// LOCKED | owner is mid-packet; only owner is accepted until its last beat
module stream_mux_rr #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          in_valid,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  input  logic [N_IN-1:0]          in_last,
  output logic [N_IN-1:0]          in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  typedef enum logic [0:0] {IDLE, LOCKED} state_t;

  localparam logic [SEL_W:0]   N_W      = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   rr_ptr, rr_nxt;
  logic [SEL_W-1:0]   owner, owner_nxt;
  logic [SEL_W-1:0]   cand;
  logic               cand_found;
  logic [SEL_W:0]     idx_w;
  logic [SEL_W-1:0]   grant_sel;
  logic               load_en;
  logic               accept;
  logic               acc_last;

  assign load_en = !out_valid | out_ready;

  // First valid input at or after rr_ptr, wrapping past N_IN-1.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    idx_w      = '0;
    for (int k = 0; k < N_IN; k++) begin
      idx_w = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      if (idx_w >= N_W) idx_w = idx_w - N_W;
      if (!cand_found && in_valid[idx_w[SEL_W-1:0]]) begin
        cand       = idx_w[SEL_W-1:0];
        cand_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_sel = (state == LOCKED) ? owner : cand;
    in_ready  = '0;
    if (!rst && (state == LOCKED || cand_found)) begin
      in_ready[grant_sel] = load_en;
    end
    accept   = |(in_valid & in_ready);
    acc_last = in_last[grant_sel];
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (accept) begin
          rr_nxt = (cand == LAST_IDX) ? '0 : cand + 1'b1;
          if (!acc_last) begin
            state_nxt = LOCKED;
            owner_nxt = cand;
          end
        end
      end
      LOCKED: begin
        if (accept && acc_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_nxt;
      owner  <= owner_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant_sel*DATA_W +: DATA_W];
      out_last  <= acc_last;
      out_sel   <= grant_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr (N_IN=4, DATA_W=8) with hand-computed expectations.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  stream_mux_rr #(.N_IN(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic v, input logic [7:0] d, input logic l);
    in_valid[i]       = v;
    in_data[i*8 +: 8] = d;
    in_last[i]        = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic l, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'hA0 + i), 1'b1);
    #2;
    chk_out("rst", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("rst.in_ready", 32'(in_ready), 32'h0);
    tick;
    chk("rst.in_ready_clk", 32'(in_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'b0001);

    // round robin, single-beat packets
    for (int k = 0; k < 5; k++) begin
      tick;
      chk_out($sformatf("rr%0d", k), 1'b1, 8'(8'hA0 + (k % 4)), 1'b1, 2'(k % 4));
      chk($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
    end
    in_valid = '0;
    tick;
    chk_out("drain", 1'b0, 8'hA0, 1'b1, 2'd0);

    // packet lock: rr_ptr=1, input 2 wins over input 0
    set_ch(0, 1'b1, 8'h55, 1'b1);
    set_ch(2, 1'b1, 8'h11, 1'b0);
    #1;
    chk("lock.ir0", 32'(in_ready), 32'b0100);
    tick;
    chk_out("lock.b0", 1'b1, 8'h11, 1'b0, 2'd2);
    set_ch(2, 1'b1, 8'h22, 1'b0);
    #1;
    chk("lock.ir1", 32'(in_ready), 32'b0100);
    tick;
    chk_out("lock.b1", 1'b1, 8'h22, 1'b0, 2'd2);
    set_ch(2, 1'b1, 8'h33, 1'b1);
    #1;
    chk("lock.ir2", 32'(in_ready), 32'b0100);
    tick;
    chk_out("lock.b2", 1'b1, 8'h33, 1'b1, 2'd2);
    set_ch(2, 1'b0, 8'h00, 1'b0);
    #1;
    chk("lock.ir3", 32'(in_ready), 32'b0001);
    tick;
    chk_out("lock.next", 1'b1, 8'h55, 1'b1, 2'd0);
    set_ch(0, 1'b0, 8'h00, 1'b0);
    tick;
    chk("lock.idle", 32'(out_valid), 32'h0);

    // backpressure mid-packet on input 1 (rr_ptr=1)
    set_ch(1, 1'b1, 8'h10, 1'b0);
    tick;
    chk_out("bp.b0", 1'b1, 8'h10, 1'b0, 2'd1);
    set_ch(1, 1'b1, 8'h11, 1'b0);
    out_ready = 1'b0;
    #1;
    chk("bp.ir_stall", 32'(in_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk_out($sformatf("bp.hold%0d", k), 1'b1, 8'h10, 1'b0, 2'd1);
      chk($sformatf("bp.hold%0d.ir", k), 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.ir_resume", 32'(in_ready), 32'b0010);
    tick;
    chk_out("bp.b1", 1'b1, 8'h11, 1'b0, 2'd1);
    set_ch(1, 1'b1, 8'h12, 1'b0);
    tick;
    chk_out("bp.b2", 1'b1, 8'h12, 1'b0, 2'd1);
    set_ch(1, 1'b1, 8'h13, 1'b1);
    tick;
    chk_out("bp.b3", 1'b1, 8'h13, 1'b1, 2'd1);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    tick;
    chk("bp.idle", 32'(out_valid), 32'h0);

    // pointer wrap: single beat from input 2 moves rr_ptr to 3
    set_ch(2, 1'b1, 8'h2C, 1'b1);
    tick;
    chk_out("wrap.pre", 1'b1, 8'h2C, 1'b1, 2'd2);
    set_ch(2, 1'b0, 8'h00, 1'b0);
    set_ch(1, 1'b1, 8'h31, 1'b1);
    set_ch(3, 1'b1, 8'h33, 1'b1);
    #1;
    chk("wrap.ir3", 32'(in_ready), 32'b1000);
    tick;
    chk_out("wrap.g3", 1'b1, 8'h33, 1'b1, 2'd3);
    set_ch(3, 1'b0, 8'h00, 1'b0);
    #1;
    chk("wrap.ir1", 32'(in_ready), 32'b0010);
    tick;
    chk_out("wrap.g1", 1'b1, 8'h31, 1'b1, 2'd1);
    set_ch(1, 1'b0, 8'h00, 1'b0);
    tick;

    // mid-packet reset on beat 2 of a 4-beat packet from input 2 (rr_ptr=2)
    set_ch(2, 1'b1, 8'h41, 1'b0);
    tick;
    chk_out("mr.b0", 1'b1, 8'h41, 1'b0, 2'd2);
    set_ch(2, 1'b1, 8'h42, 1'b0);
    tick;
    chk_out("mr.b1", 1'b1, 8'h42, 1'b0, 2'd2);
    set_ch(2, 1'b1, 8'h43, 1'b0);
    set_ch(0, 1'b1, 8'h05, 1'b1);
    rst = 1'b1;
    #1;
    chk_out("mr.rst", 1'b0, 8'h00, 1'b0, 2'd0);
    chk("mr.rst.ir", 32'(in_ready), 32'h0);
    tick;
    rst = 1'b0;
    #1;
    chk("mr.rel.ir", 32'(in_ready), 32'b0001);
    tick;
    chk_out("mr.g0", 1'b1, 8'h05, 1'b1, 2'd0);
    chk("mr.g0.ir", 32'(in_ready), 32'b0100);

    in_valid = '0;
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
